nios2_system_key_pio: RTL
=========================

# nios2_system_key_pio

Avalon-MM slave input PIO for the pushbutton/switch bank: the input-direction counterpart of the LED output PIOs on the Nios II system bus. Synchronises and debounces WIDTH asynchronous pins and captures qualifying edges into sticky bits. Exposes the debounced level and capture bits to the CPU, and raises a maskable level interrupt.

## Interface
- WIDTH, 4, number of input pins.
- DEBOUNCE_CYCLES, 50000, consecutive clk cycles a changed level must hold before acceptance; legal range 1..2^20.
- EDGE_TYPE, 1, edges captured: 0 rising, 1 falling, 2 both.
- IDLE_LEVEL, {WIDTH{1'b1}}, reset value of the synchroniser and debounced level (keys are active-low).

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  word register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational, zero-extended above WIDTH.
- in_port  in  WIDTH  raw asynchronous pins.
- irq  out  1  level interrupt to the CPU.

## Operation
- Register map: addr 0 DATA (debounced level, RO); addr 1 reserved, reads 0, writes ignored; addr 2 IRQMASK (RW, WIDTH bits); addr 3 EDGECAPTURE (RO, write-1-to-clear per bit).
- A write occurs on a cycle where chipselect=1 and write_n=0. Reads have no side effects. Writes to addr 0/1 are ignored.
- Synchroniser: 2-flop chain per bit (sync1 -> sync2). Both stages reset to IDLE_LEVEL.
- Debounce uses a per-bit counter, ceil(log2(DEBOUNCE_CYCLES))+1 bits, counting 0..DEBOUNCE_CYCLES-1. Each clk:
  - sync2[i] == stable[i]: cnt[i] <= 0.
  - otherwise, if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync2[i] and cnt[i] <= 0.
  - otherwise: cnt[i] <= cnt[i]+1.
  - A bounce back to the stable value resets the count, so any pulse shorter than DEBOUNCE_CYCLES cycles is discarded.
- Edge capture: on the same edge stable[i] updates, EDGECAPTURE[i] sets if the transition matches EDGE_TYPE (rising 0->1, falling 1->0). The bit stays set until cleared.
- Clear: a write to addr 3 clears each bit where writedata[i]=1. If a set event and a clear of the same bit occur in the same cycle, set wins.
- irq = |(EDGECAPTURE & IRQMASK), combinational from registers. There is no other irq state.
- Reset values: stable = IDLE_LEVEL, cnt = 0, IRQMASK = 0, EDGECAPTURE = 0, irq = 0. readdata follows address with registers at their reset values.
- Reset mid-debounce aborts the count. Because of the IDLE_LEVEL reset, no capture is generated by reset release itself.

## Timing
- Let in_port change and remain stable from before clk edge E0.
  - sync2 updates at E1.
  - stable and EDGECAPTURE update at E(DEBOUNCE_CYCLES+1).
  - irq is high after that edge when the bit is masked in.
- DATA read latency: 0 cycles (combinational readdata, no waitstates).
- IRQMASK write takes effect on the following edge. irq responds in the same cycle after that edge.
- An EDGECAPTURE clear at edge Ek drops irq after Ek, unless a new set occurs at Ek.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> irq=0, DATA reads 0xF, IRQMASK reads 0, EDGECAPTURE reads 0 immediately, with no clk required.
- Clean press, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, IRQMASK=0x1: drive in_port 0xF->0xE before E0 -> DATA reads 0xE and EDGECAPTURE reads 0x1 after E5 (not after E4), and irq=1 after E5.
- Glitch filter, DEBOUNCE_CYCLES=4: in_port[1] low for 3 cycles, then high -> DATA stays 0xF, EDGECAPTURE stays 0, and irq stays 0.
- Masking, EDGE_TYPE=2: toggle bit 2 low then high with IRQMASK=0 -> EDGECAPTURE=0x4 and irq=0; then write IRQMASK=0x4 -> irq=1 the next cycle.
- Clear: with EDGECAPTURE=0x5, write 0x1 to addr 3 -> reads 0x4. Then clear bit 2 on the same edge a new bit-2 edge is captured -> bit 2 remains 1.
- Reset mid-debounce: start a bit-0 press, assert reset at count 2, release while the pin is held low -> the press is accepted DEBOUNCE_CYCLES+2 edges after reset release, with exactly one capture.

Source files
------------

// File: rtl/nios2_system_key_pio.sv
// Avalon-MM input PIO for the key/switch bank: synchronise, debounce, capture edges
// into sticky bits, and raise a maskable level interrupt.
module nios2_system_key_pio #(
    parameter int unsigned     WIDTH           = 4,
    parameter int unsigned     DEBOUNCE_CYCLES = 50000,
    parameter int unsigned     EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] IDLE_LEVEL     = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;

    logic [WIDTH-1:0] accept_c;
    logic [WIDTH-1:0] rise_c;
    logic [WIDTH-1:0] fall_c;
    logic [WIDTH-1:0] set_c;
    logic [WIDTH-1:0] clr_c;
    logic             wr_c;
    logic             unused_wdata;

    assign unused_wdata = ^writedata[31:WIDTH];
    assign wr_c         = chipselect & ~write_n;

    // Two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // A bit is accepted once it has differed from stable for DEBOUNCE_CYCLES clocks
    always_comb begin
        accept_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            accept_c[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
        rise_c = accept_c & sync2 & ~stable;
        fall_c = accept_c & ~sync2 & stable;
        if (EDGE_TYPE == 0) begin
            set_c = rise_c;
        end else if (EDGE_TYPE == 1) begin
            set_c = fall_c;
        end else begin
            set_c = rise_c | fall_c;
        end
        clr_c = (wr_c && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= IDLE_LEVEL;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept_c[i]) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Set beats clear when both hit the same bit in one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask <= '0;
            edgecap <= '0;
        end else begin
            if (wr_c && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            edgecap <= (edgecap & ~clr_c) | set_c;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = 32'(stable);
            2'd2:    readdata = 32'(irqmask);
            2'd3:    readdata = 32'(edgecap);
            default: readdata = '0;
        endcase
    end

    assign irq = |(edgecap & irqmask);

endmodule
